// File: rtl/div16s_8_seq.sv
// Sequential signed divider: 16-bit dividend / 8-bit divisor -> 8-bit quotient
// and remainder. Radix-2 restoring division on magnitudes, one quotient bit
// per cycle, truncation toward zero, saturating quotient with overflow flag.
module div16s_8_seq #(
    parameter int AW = 16,
    parameter int BW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [AW-1:0] A,
    input  logic signed [BW-1:0] B,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic        [BW-1:0] Q,
    output logic        [BW-1:0] R,
    output logic                 ovf,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int CW = $clog2(AW);
    localparam logic [AW-1:0] QPOS_MAX = AW'((1 << (BW - 1)) - 1);
    localparam logic [AW-1:0] QNEG_MAX = AW'(1 << (BW - 1));
    localparam logic [BW-1:0] SAT_HI   = {1'b0, {(BW - 1){1'b1}}};
    localparam logic [BW-1:0] SAT_LO   = {1'b1, {(BW - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [AW-1:0] work;    // dividend shifts out of the MSB, quotient bits enter the LSB
    logic [BW:0]   prem;    // partial remainder
    logic [BW-1:0] b_mag;
    logic          a_neg;
    logic          q_neg;
    logic [CW-1:0] cnt;

    logic [AW-1:0] a_abs;
    logic [BW-1:0] b_abs;
    logic [BW:0]   prem_sh;
    logic [BW+1:0] trial;
    logic          q_ovf;
    logic [BW-1:0] q_fin;
    logic [BW-1:0] r_fin;

    // Operand magnitudes and one restoring-division step
    always_comb begin
        a_abs   = A[AW-1] ? (~A + 1'b1) : A;
        b_abs   = B[BW-1] ? (~B + 1'b1) : B;
        prem_sh = {prem[BW-1:0], work[AW-1]};
        trial   = {1'b0, prem_sh} - {2'b00, b_mag};
    end

    // Sign correction and saturation of the final result
    always_comb begin
        q_ovf = q_neg ? (work > QNEG_MAX) : (work > QPOS_MAX);
        if (q_ovf)
            q_fin = q_neg ? SAT_LO : SAT_HI;
        else
            q_fin = q_neg ? ('0 - work[BW-1:0]) : work[BW-1:0];
        r_fin = a_neg ? ('0 - prem[BW-1:0]) : prem[BW-1:0];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_next = (B == '0) ? DONE : CALC;
            end
            CALC: begin
                if (cnt == '0)
                    state_next = FIN;
            end
            FIN: begin
                state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work  <= '0;
            prem  <= '0;
            b_mag <= '0;
            a_neg <= 1'b0;
            q_neg <= 1'b0;
            cnt   <= '0;
            Q     <= '0;
            R     <= '0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        work  <= a_abs;
                        b_mag <= b_abs;
                        a_neg <= A[AW-1];
                        q_neg <= A[AW-1] ^ B[BW-1];
                        prem  <= '0;
                        cnt   <= CW'(AW - 1);
                        if (B == '0) begin
                            Q   <= A[AW-1] ? SAT_LO : SAT_HI;
                            R   <= '0;
                            ovf <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (!trial[BW+1]) begin
                        prem <= trial[BW:0];
                        work <= {work[AW-2:0], 1'b1};
                    end else begin
                        prem <= prem_sh;
                        work <= {work[AW-2:0], 1'b0};
                    end
                    cnt <= cnt - 1'b1;
                end
                FIN: begin
                    Q   <= q_fin;
                    R   <= r_fin;
                    ovf <= q_ovf;
                end
                default: ;
            endcase
        end
    end

endmodule
